// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PC_W       = 64;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Big-endian byte packer: lane for cap_cnt 0 is bits [31:24]; o_merged shows the register with
// the incoming byte already placed, so the final byte can be consumed in the same cycle.
module byte_lane_packer
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    i_clear,
  input  logic                    i_wr_en,
  input  logic [1:0]              i_cap_cnt,
  input  logic [7:0]              i_byte,
  output logic [8*INST_BYTES-1:0] o_merged
);

  logic [8*INST_BYTES-1:0] r_shift;

  genvar gi;
  generate
    for (gi = 0; gi < INST_BYTES; gi++) begin : g_lane
      assign o_merged[8*gi +: 8] = (i_cap_cnt == 2'(INST_BYTES - 1 - gi)) ? i_byte
                                                                          : r_shift[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_shift <= '0;
    end else if (i_wr_en) begin
      r_shift <= o_merged;
    end
  end

endmodule

// File: rtl/inst_fetch_assembler.sv
// Fetch PC owner: issues four byte reads per instruction, assembles them big-endian and offers
// {inst, inst_pc} to decode. Define FETCH_BOUND_CHECK_EN to trap fetches beyond MEM_BYTES.
module inst_fetch_assembler
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     MEM_BYTES = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_stop,
  input  logic [7:0]      mem_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            fault
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_base;
  logic [PC_W-1:0] r_inst_pc;
  logic [1:0]      r_issue_cnt;
  logic [1:0]      r_cap_cnt;
  logic [31:0]     r_inst;
  logic            r_inst_valid;

  logic            w_accept;
  logic            w_capture;
  logic            w_clear;
  logic [PC_W-1:0] w_next_base;
  logic [31:0]     w_merged;
  fetch_state_t    w_entry_state;

  generate
    if (MEM_BYTES < INST_BYTES) begin : g_bad_mem_size
      $error("MEM_BYTES must hold at least one instruction");
    end
  endgenerate

  assign w_accept    = r_inst_valid & inst_ready;
  assign w_next_base = redirect ? (redirect_pc & ~PC_W'(3)) : (r_base + PC_W'(INST_BYTES));
  // The byte returned in the first FETCH cycle belongs to whatever was issued before, so skip it.
  assign w_capture   = ((r_state == FETCH) && (r_issue_cnt != 2'd0)) || (r_state == DRAIN);
  assign w_clear     = reset | redirect | w_accept;

`ifdef FETCH_BOUND_CHECK_EN
  assign w_entry_state = (({1'b0, w_next_base} + (PC_W+1)'(INST_BYTES - 1)) >= (PC_W+1)'(MEM_BYTES))
                         ? FAULT : FETCH;
  assign fault         = (r_state == FAULT);
`else
  assign w_entry_state = FETCH;
  assign fault         = 1'b0;
`endif

  assign mem_addr   = (r_state == FETCH) ? (r_base + PC_W'(r_issue_cnt)) : r_base;
  assign mem_stop   = reset | (r_state != FETCH);
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  byte_lane_packer u_packer (
    .clk       (clk),
    .i_clear   (w_clear),
    .i_wr_en   (w_capture),
    .i_cap_cnt (r_cap_cnt),
    .i_byte    (mem_data),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_base       <= RESET_PC;
      r_issue_cnt  <= 2'd0;
      r_cap_cnt    <= 2'd0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else if (redirect) begin
      r_state      <= w_entry_state;
      r_base       <= w_next_base;
      r_issue_cnt  <= 2'd0;
      r_cap_cnt    <= 2'd0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_issue_cnt <= r_issue_cnt + 2'd1;
          if (r_issue_cnt != 2'd0) r_cap_cnt <= r_cap_cnt + 2'd1;
          if (r_issue_cnt == 2'd3) r_state <= DRAIN;
        end
        DRAIN: begin
          r_inst       <= w_merged;
          r_inst_pc    <= r_base;
          r_inst_valid <= 1'b1;
          r_issue_cnt  <= 2'd0;
          r_cap_cnt    <= 2'd0;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (w_accept) begin
            r_base       <= w_next_base;
            r_inst_valid <= 1'b0;
            r_state      <= w_entry_state;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_assembler.md
# inst_fetch_assembler

Reader side of the byte-wide instruction code memory. It drives byte addresses into the code memory and collects the four returned bytes big-endian, first byte into bits [31:24]. It presents each complete 32-bit instruction with its PC to the decode stage over a valid/ready handshake. It sits between the code memory and the decoder and owns the architectural fetch PC, including branch redirects.

## Interface
- `RESET_PC`, default 0: byte address fetched first after reset.
- `MEM_BYTES`, default 64: code memory size in bytes; used only by the bound check.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  out  64  byte address to the code memory; combinational from registered state.
- `mem_stop`  out  1  stop to the code memory. While high, the memory returns 0 on the next cycle.
- `mem_data`  in  8  registered memory byte; returns the byte for the address presented in the previous cycle.
- `redirect`  in  1  one-cycle pulse: abandon the current fetch and restart at `redirect_pc`.
- `redirect_pc`  in  64  redirect target; bits [1:0] are forced to 0.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid.
- `inst_ready`  in  1  decoder accepts when `inst_valid & inst_ready`.
- `inst`  out  32  assembled instruction.
- `inst_pc`  out  64  byte address of the instruction's first byte.
- `fault`  out  1  out-of-range fetch; present only with the macro, otherwise tied 0.

## Operation
- Registers:
  - `base`: current instruction address.
  - `issue_cnt` (0..3) and `cap_cnt` (0..3).
  - `shift`: 32-bit assembly register.
- States are FETCH, DRAIN, HOLD and FAULT.
- FETCH:
  - `mem_addr = base + issue_cnt`, `mem_stop = 0`; `issue_cnt` increments every cycle.
  - From the second FETCH cycle onward, the byte on `mem_data` goes into `shift[31-8*cap_cnt -: 8]` and `cap_cnt` increments.
  - After `issue_cnt` = 3 is issued, go to DRAIN.
- DRAIN: `mem_stop = 1`. Capture byte 3, load `inst <= shift` with byte 3 merged and `inst_pc <= base`, then go to HOLD.
- HOLD:
  - `inst_valid = 1`, `mem_stop = 1`; `inst` and `inst_pc` stay stable.
  - On accept: `base <= base + 4`, counters clear, go to FETCH.
- Redirect has priority in every state:
  - `base <= {redirect_pc[63:2], 2'b00}`, counters clear, `inst_valid` drops next cycle, go to FETCH.
  - The byte in flight is discarded.
  - If redirect and accept occur in the same cycle, the instruction counts as consumed and the redirect target becomes the next `base`.
- Arithmetic is unsigned 64-bit; `base + 4` wraps modulo 2^64.
- `mem_addr` is `base` whenever not in FETCH.

## Timing
- Reset values: `base = RESET_PC`, state FETCH (first cycle after reset deasserts), counters 0, `inst = 0`, `inst_pc = 0`, `inst_valid = 0`, `mem_stop = 1` while `reset` is high, `fault = 0`.
- Latency: FETCH entered at cycle F → bytes issued at F..F+3, captured at F+1..F+4, `inst_valid` high at F+5.
- Throughput: one instruction per 6 cycles with `inst_ready` held high (accept at F+5, next FETCH at F+6).
- Redirect at cycle R → `mem_addr` = target at R+1.
- Reset mid-fetch: all partial state is discarded; the restart at `RESET_PC` follows the reset-release timing.

## Configuration
- `FETCH_BOUND_CHECK_EN` defined:
  - On entering FETCH, if `base + 3 >= MEM_BYTES`, go to FAULT instead.
  - FAULT holds `fault = 1`, `mem_stop = 1`, `inst_valid = 0`.
  - FAULT is left only by `redirect` (re-checked) or `reset`.
- Undefined: no check. Addresses pass through unmodified, and `fault` is constant 0.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (FETCH, DRAIN, HOLD, FAULT).
  - `INST_BYTES = 4`.
  - `PC_W = 64`.
- One sub-module, `byte_lane_packer`: takes `cap_cnt` and an 8-bit byte and writes the big-endian lane into the 32-bit register, with a clear input.

## Test plan
- Memory 0..3 = F8 00 04 01, `inst_ready = 1` after reset → `inst = 32'hF8000401`, `inst_pc = 0`, `inst_valid` at 5th cycle after reset release.
- Bytes 4..7 = FC 40 04 23, `inst_ready` low 3 cycles → `inst = 32'hFC400423` stable, `mem_stop = 1` throughout HOLD, next `mem_addr = 8` after accept.
- `redirect_pc = 36` during byte 2 of fetch at 8 → discarded; next `inst = 32'h910021AF`, `inst_pc = 36`.
- `redirect_pc = 27` (unaligned) → fetch from 24, `inst = 32'hD2BFFFED`, `inst_pc = 24`.
- Redirect to 64, with `FETCH_BOUND_CHECK_EN` → `fault = 1`, no `inst_valid`, `mem_stop = 1`; a redirect to 0 then clears the fault. Without the macro → `mem_addr` 64..67 issued.
- `reset` pulsed during DRAIN → `inst_valid = 0`, `inst = 0`, fetch restarts at `RESET_PC = 0`.
